// File: rtl/csa_resolver_pkg.sv
// Shared types and sizing helpers for the carry-save resolver.
package csa_resolver_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Bits needed to count from 0 up to and including width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/csa_ha_row.sv
// One full-width half-adder row: collapses one level of a (sum, carry) pair.
module csa_ha_row #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] half_sum,
  output logic [WIDTH-1:0] half_carry,
  output logic             msb_carry
);

  // Bit 0 never receives a carry; each generated carry moves up one weight.
  assign half_carry[0] = 1'b0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign half_sum[gi] = s[gi] ^ c[gi];
    if (gi < WIDTH - 1) begin : g_carry
      assign half_carry[gi+1] = s[gi] & c[gi];
    end
  end

  // Carry generated at the top bit falls off the word and feeds the sticky overflow.
  assign msb_carry = s[WIDTH-1] & c[WIDTH-1];

endmodule

// File: rtl/csa_resolver.sv
// Iterative carry-save to binary resolver.
// Optional build macro CSR_EARLY_EXIT_EN: stop as soon as the carry vector is zero
// (data-dependent latency) instead of always applying WIDTH steps.
module csa_resolver
  import csa_resolver_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           sum_in,
  input  logic [WIDTH-1:0]           carry_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           result,
  output logic                       carry_out,
  output logic [$clog2(WIDTH+1)-1:0] iter_count
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  state_t          state_reg;
  state_t          state_next;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] c_reg;
  logic            ovf_reg;
  logic [CW-1:0]   cnt_reg;

  logic [WIDTH-1:0] half_sum;
  logic [WIDTH-1:0] half_carry;
  logic            msb_carry;
  logic            terminate;
  logic            accept;
  logic            step;

  csa_ha_row #(.WIDTH(WIDTH)) u_row (
    .s          (s_reg),
    .c          (c_reg),
    .half_sum   (half_sum),
    .half_carry (half_carry),
    .msb_carry  (msb_carry)
  );

`ifdef CSR_EARLY_EXIT_EN
  assign terminate = (c_reg == '0) || (cnt_reg == CNT_MAX);
`else
  assign terminate = (cnt_reg == CNT_MAX);
`endif

  // Next-state and datapath control; DONE->IDLE never overlaps an accept.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RESOLVE;
        end
      end
      RESOLVE: begin
        if (terminate) begin
          state_next = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and working registers; outputs are taken straight from these.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      c_reg     <= '0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        s_reg   <= sum_in;
        c_reg   <= carry_in;
        ovf_reg <= 1'b0;
        cnt_reg <= '0;
      end else if (step) begin
        s_reg   <= half_sum;
        c_reg   <= half_carry;
        ovf_reg <= ovf_reg | msb_carry;
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign result     = s_reg;
  assign carry_out  = ovf_reg;
  assign iter_count = cnt_reg;

endmodule

// File: tb/tb_csa_resolver.sv
// Directed and random checks of csa_resolver at WIDTH=8 (either build).
module tb_csa_resolver;

  localparam int W = 8;
`ifdef CSR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] sum_in;
  logic [7:0] carry_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry_out;
  logic [3:0] iter_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csa_resolver #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum_in     (sum_in),
    .carry_in   (carry_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry_out  (carry_out),
    .iter_count (iter_count)
  );

  // Offer one pair from IDLE, return outputs and the cycle index at which
  // out_valid is first seen (cycle 1 = the cycle right after the accept edge),
  // then hold off out_ready for 'hold' cycles and complete the handshake.
  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                          output logic [7:0] r, output logic co, output logic [3:0] n,
                          output int lat, output bit to);
    @(negedge clk);
    sum_in = a; carry_in = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; sum_in = ~a; carry_in = ~b;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !out_valid;
    r = result; co = carry_out; n = iter_count;
    repeat (hold) @(posedge clk);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sum_in = 8'h00; carry_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got=%h want=00", result); end
    n_cmp++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_carry_out got=%b want=0", carry_out); end
    n_cmp++; if (iter_count !== 4'd0) begin n_fail++; $display("FAIL reset_iter_count got=%0d want=0", iter_count); end
    $display("RESET: out_valid=%b in_ready=%b result=%h", out_valid, in_ready, result);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] va [6] = '{8'h01, 8'hFF, 8'hA5, 8'h0F, 8'h80, 8'h55};
    logic [7:0] vb [6] = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h80, 8'hAA};
    logic [7:0] vr [6] = '{8'h02, 8'h00, 8'hA5, 8'h10, 8'h00, 8'hFF};
    logic       vc [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    int         vk [6] = '{2,     8,     0,     5,     1,     1};
    logic [7:0] r; logic co; logic [3:0] n; int lat; bit to;
    int ek;
    for (int i = 0; i < 6; i++) begin
      ek = EE ? vk[i] : W;
      drive_op(va[i], vb[i], 0, r, co, n, lat, to);
      $display("DIRECTED %0d: %h+%h -> result=%h carry_out=%b iter=%0d latency=%0d", i, va[i], vb[i], r, co, n, lat);
      n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL dir%0d_timeout got=timeout want=out_valid", i); end
      n_cmp++; if (r !== vr[i]) begin n_fail++; $display("FAIL dir%0d_result got=%h want=%h", i, r, vr[i]); end
      n_cmp++; if (co !== vc[i]) begin n_fail++; $display("FAIL dir%0d_carry_out got=%b want=%b", i, co, vc[i]); end
      n_cmp++; if (n !== 4'(ek)) begin n_fail++; $display("FAIL dir%0d_iter got=%0d want=%0d", i, n, ek); end
      n_cmp++; if (lat !== ek + 2) begin n_fail++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, ek + 2); end
      n_cmp++; if (result !== vr[i] || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL dir%0d_idle_hold got=%h/%b want=%h/1", i, result, in_ready, vr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int ek;
    ek = EE ? 4 : W;
    @(negedge clk);
    sum_in = 8'h3C; carry_in = 8'h0F; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=%b want=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_valid = 1'b1; sum_in = 8'h11; carry_in = 8'h22;
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d_hs got=%b/%b want=1/0", i, out_valid, in_ready);
      end
      n_cmp++; if (result !== 8'h4B || carry_out !== 1'b0 || iter_count !== 4'(ek)) begin
        n_fail++; $display("FAIL bp_hold%0d_data got=%h/%b/%0d want=4b/0/%0d", i, result, carry_out, iter_count, ek);
      end
    end
    // Release with in_valid still high: the release edge must not also accept.
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 8'h4B) begin
      n_fail++; $display("FAIL bp_release got=%b/%b/%h want=1/0/4b", in_ready, out_valid, result);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept got=%b want=0", in_ready); end
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    ek = EE ? 1 : W;
    n_cmp++; if (result !== 8'h33 || carry_out !== 1'b0 || lat !== ek + 2) begin
      n_fail++; $display("FAIL bp_next got=%h/%b/lat%0d want=33/0/lat%0d", result, carry_out, lat, ek + 2);
    end
    $display("BACKPRESSURE: held 4b, then 11+22 -> %h latency=%0d", result, lat);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] r; logic co; logic [3:0] n; int lat; bit to;
    @(negedge clk);
    sum_in = 8'hFF; carry_in = 8'h01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_hs got=%b/%b want=0/1", out_valid, in_ready);
    end
    n_cmp++; if (result !== 8'h00 || carry_out !== 1'b0 || iter_count !== 4'd0) begin
      n_fail++; $display("FAIL midrst_data got=%h/%b/%0d want=00/0/0", result, carry_out, iter_count);
    end
    @(negedge clk); rst = 1'b0;
    drive_op(8'h0F, 8'h01, 1, r, co, n, lat, to);
    $display("RESET_MID: then 0f+01 -> result=%h carry_out=%b iter=%0d", r, co, n);
    n_cmp++; if (to !== 1'b0 || r !== 8'h10 || co !== 1'b0 || n !== 4'(EE ? 5 : W)) begin
      n_fail++; $display("FAIL midrst_after got=%h/%b/%0d want=10/0/%0d", r, co, n, EE ? 5 : W);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, r; logic co; logic [3:0] n; int lat; bit to;
    logic [8:0] exp;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      exp = {1'b0, a} + {1'b0, b};
      drive_op(a, b, int'($urandom_range(0, 3)), r, co, n, lat, to);
      $display("RAND %0d: %h+%h -> result=%h carry_out=%b iter=%0d", i, a, b, r, co, n);
      n_cmp++; if (to !== 1'b0 || {co, r} !== exp) begin
        n_fail++; $display("FAIL rand%0d_sum got=%b/%h want=%h", i, co, r, exp);
      end
      n_cmp++; if ((EE ? (n > 4'd8) : (n !== 4'd8)) || lat !== int'(n) + 2) begin
        n_fail++; $display("FAIL rand%0d_iter got=%0d/lat%0d want<=8/lat=iter+2", i, n, lat);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
